// File: rtl/vga_pkg.sv
// vga_pkg: timing constants for 800x600@60 (40 MHz pixel clock), shared by the
// transmit-side generator and the receive-side tracker, plus the common types.
//   - H_*/V_* : period, first blank count, sync start, first count after sync
//   - CW      : counter width (11 bits covers 1055 and 627)
//   - ERR_W   : width of the saturating mismatch counter
//   - rx_state_e : tracker states
//   - vga_sync_t : the four timing bits, in hsync/vsync/hblnk/vblnk order
package vga_pkg;
  localparam int H_TOTAL      = 1056;
  localparam int H_ACTIVE     = 800;
  localparam int H_SYNC_START = 840;
  localparam int H_SYNC_END   = 968;
  localparam int V_TOTAL      = 628;
  localparam int V_ACTIVE     = 600;
  localparam int V_SYNC_START = 601;
  localparam int V_SYNC_END   = 605;

  localparam int CW    = 11;
  localparam int ERR_W = 8;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} rx_state_e;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic hblnk;
    logic vblnk;
  } vga_sync_t;
endpackage

// File: rtl/vga_timing_rx_if.sv
// vga_timing_rx_if: bus between a sync-only video source/consumer and the
// timing receiver.
//   master : drives hsync_in/vsync_in/hblnk_in/vblnk_in and err_clr, reads the
//            rebuilt timing bundle and status
//   slave  : the receiver side (vga_timing_rx)
interface vga_timing_rx_if;
  import vga_pkg::*;

  logic             hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic             err_clr;
  logic [CW-1:0]    hcount, vcount;
  logic             hsync, vsync, hblnk, vblnk;
  logic             locked, mismatch;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output hsync_in, vsync_in, hblnk_in, vblnk_in, err_clr,
    input  hcount, vcount, hsync, vsync, hblnk, vblnk, locked, mismatch, err_cnt
  );

  modport slave (
    input  hsync_in, vsync_in, hblnk_in, vblnk_in, err_clr,
    output hcount, vcount, hsync, vsync, hblnk, vblnk, locked, mismatch, err_cnt
  );
endinterface

// File: rtl/vga_timing_expect.sv
// vga_timing_expect: combinational map from a counter position (h,v) to the
// hsync/vsync/hblnk/vblnk levels that position must carry. The generator and
// the receiver both use this, so they cannot disagree on the waveform.
//   hcount, vcount : counter position (in)
//   sync           : expected timing bits (out)
module vga_timing_expect #(
  parameter int H_ACTIVE     = vga_pkg::H_ACTIVE,
  parameter int H_SYNC_START = vga_pkg::H_SYNC_START,
  parameter int H_SYNC_END   = vga_pkg::H_SYNC_END,
  parameter int V_ACTIVE     = vga_pkg::V_ACTIVE,
  parameter int V_SYNC_START = vga_pkg::V_SYNC_START,
  parameter int V_SYNC_END   = vga_pkg::V_SYNC_END
) (
  input  logic [vga_pkg::CW-1:0] hcount,
  input  logic [vga_pkg::CW-1:0] vcount,
  output vga_pkg::vga_sync_t     sync
);
  import vga_pkg::*;

  assign sync.hblnk = (hcount >= CW'(H_ACTIVE));
  assign sync.hsync = (hcount >= CW'(H_SYNC_START)) && (hcount < CW'(H_SYNC_END));
  assign sync.vblnk = (vcount >= CW'(V_ACTIVE));
  // vsync depends on the line only, so it toggles together with the line at h=0
  assign sync.vsync = (vcount >= CW'(V_SYNC_START)) && (vcount < CW'(V_SYNC_END));
endmodule

// File: rtl/vga_timing_rx.sv
// vga_timing_rx: rebuilds hcount/vcount from a bare hsync/vsync/hblnk/vblnk
// stream and checks that stream against the expected timing every cycle.
//   clk40MHz : pixel clock
//   rst_n    : asynchronous active-low reset
//   bus      : slave side of vga_timing_rx_if
//              in : hsync_in, vsync_in, hblnk_in, vblnk_in, err_clr
//              out: hcount, vcount, hsync, vsync, hblnk, vblnk (aligned, 2-cycle
//                   latency), locked, mismatch (1-cycle pulse), err_cnt (saturating)
module vga_timing_rx #(
  parameter int H_TOTAL      = vga_pkg::H_TOTAL,
  parameter int H_ACTIVE     = vga_pkg::H_ACTIVE,
  parameter int H_SYNC_START = vga_pkg::H_SYNC_START,
  parameter int H_SYNC_END   = vga_pkg::H_SYNC_END,
  parameter int V_TOTAL      = vga_pkg::V_TOTAL,
  parameter int V_ACTIVE     = vga_pkg::V_ACTIVE,
  parameter int V_SYNC_START = vga_pkg::V_SYNC_START,
  parameter int V_SYNC_END   = vga_pkg::V_SYNC_END
) (
  input  logic           clk40MHz,
  input  logic           rst_n,
  vga_timing_rx_if.slave bus
);
  import vga_pkg::*;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  vga_sync_t        in_w, s1, s2, exp_w;
  rx_state_e        state, state_nx;
  logic [CW-1:0]    h, v, h_nx, v_nx, h_d, v_d;
  logic             fs, wrap, err, mm_d, mm_q;
  logic [ERR_W-1:0] err_q;

  assign in_w = {bus.hsync_in, bus.vsync_in, bus.hblnk_in, bus.vblnk_in};

  // s2 doubles as the registered copy of s1 that leaves the block, so it is
  // aligned with the counter register h/v.
  always_ff @(posedge clk40MHz or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_w;
      s2 <= s1;
    end
  end

  // h/v describe s2; s1 therefore must match the position one step ahead.
  always_comb begin
    h_nx = h + 1'b1;
    v_nx = v;
    wrap = 1'b0;
    if (h == H_LAST) begin
      h_nx = '0;
      if (v == V_LAST) begin
        v_nx = '0;
        wrap = 1'b1;
      end else begin
        v_nx = v + 1'b1;
      end
    end
  end

  vga_timing_expect #(
    .H_ACTIVE    (H_ACTIVE),
    .H_SYNC_START(H_SYNC_START),
    .H_SYNC_END  (H_SYNC_END),
    .V_ACTIVE    (V_ACTIVE),
    .V_SYNC_START(V_SYNC_START),
    .V_SYNC_END  (V_SYNC_END)
  ) u_expect (
    .hcount(h_nx),
    .vcount(v_nx),
    .sync  (exp_w)
  );

  // Frame start: first active pixel after vertical blanking. hblnk also falls
  // at (0,0), so the previous hblnk level is deliberately not looked at.
  assign fs  = !s1.hblnk && !s1.vblnk && s2.vblnk;
  // A frame start away from the counter wrap is an error even if the bit
  // compare alone would not flag it.
  assign err = (exp_w != s1) || (fs && !wrap);

  always_comb begin
    state_nx = state;
    h_d      = h;
    v_d      = v;
    mm_d     = 1'b0;
    unique case (state)
      SEARCH: begin
        if (fs) begin
          state_nx = VERIFY;
          h_d      = '0;
          v_d      = '0;
        end
      end
      VERIFY, LOCKED: begin
        if (err) begin
          // counters hold; they read as 0 anyway once back in SEARCH
          state_nx = SEARCH;
          mm_d     = 1'b1;
        end else begin
          h_d = h_nx;
          v_d = v_nx;
          // error-free fs can only happen at the wrap: a full frame tracked
          if (fs) state_nx = LOCKED;
        end
      end
      default: state_nx = SEARCH;
    endcase
  end

  always_ff @(posedge clk40MHz or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEARCH;
      h     <= '0;
      v     <= '0;
      mm_q  <= 1'b0;
      err_q <= '0;
    end else begin
      state <= state_nx;
      h     <= h_d;
      v     <= v_d;
      mm_q  <= mm_d;
      // clear beats a coincident mismatch
      if (bus.err_clr)
        err_q <= '0;
      else if (mm_d && (err_q != '1))
        err_q <= err_q + 1'b1;
    end
  end

  assign bus.hcount   = (state == SEARCH) ? '0 : h;
  assign bus.vcount   = (state == SEARCH) ? '0 : v;
  assign bus.hsync    = s2.hsync;
  assign bus.vsync    = s2.vsync;
  assign bus.hblnk    = s2.hblnk;
  assign bus.vblnk    = s2.vblnk;
  assign bus.locked   = (state == LOCKED);
  assign bus.mismatch = mm_q;
  assign bus.err_cnt  = err_q;
endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx on a shrunken 12x8 raster (96-cycle frame):
// active 8, hsync 9..10, active lines 0..4, vsync on line 6.
// The driver runs an independent source, pushes expected events and aligned
// output records into queues; a monitor on the falling edge compares them.
module tb_vga_timing_rx;
  localparam int HT = 12, HA = 8, HSS = 9, HSE = 11;
  localparam int VT = 8,  VA = 5, VSS = 6, VSE = 7;
  localparam int F  = HT * VT;

  localparam int K_LOCK = 0, K_ERR = 1, K_HC = 2, K_VC = 3, K_ZERO = 4, K_MM = 5;

  typedef struct { int at; int kind; int val; } ev_t;
  typedef struct { int at; logic [3:0] sync; int h; int v; } pr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  vga_timing_rx_if bus();

  vga_timing_rx #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
    .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE)
  ) dut (
    .clk40MHz(clk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  ev_t ev_q[$];
  pr_t pipe_q[$];
  int  cyc = 0;
  int  n_chk = 0, n_fail = 0;

  // source state
  int  gh = HT - 1, gv = VT - 1;
  bit  trunc = 0, idle = 0, gl_arm = 0;
  int  gl_h = 0, gl_v = 0;
  int  exp_err;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic void ev(input int at, input int kind, input int val);
    ev_t e;
    e.at = at; e.kind = kind; e.val = val;
    ev_q.push_back(e);
  endfunction

  // one source clock: advance the raster, drive the bits, record what the
  // aligned outputs must show two edges later
  task automatic step();
    logic hs, vs, hb, vb;
    pr_t  r;
    @(posedge clk);
    cyc++;
    #1;
    if (gh == HT - 1) begin
      gh = 0;
      if (gv >= (trunc ? VT - 2 : VT - 1)) begin
        gv = 0;
        trunc = 0;
      end else gv++;
    end else gh++;
    hs = (gh >= HSS) && (gh < HSE);
    vs = (gv >= VSS) && (gv < VSE);
    hb = (gh >= HA);
    vb = (gv >= VA);
    if (gl_arm && gh == gl_h && gv == gl_v) begin
      hs = 1'b0;
      gl_arm = 0;
    end
    if (idle) {hs, vs, hb, vb} = 4'b0;
    bus.hsync_in = hs;
    bus.vsync_in = vs;
    bus.hblnk_in = hb;
    bus.vblnk_in = vb;
    if (rst_n) begin
      r.at = cyc + 2; r.sync = {hs, vs, hb, vb}; r.h = gh; r.v = gv;
      pipe_q.push_back(r);
    end
  endtask

  task automatic wait_gen(input int h, input int v);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(gh == h && gv == v) && n < 4 * F);
    if (!(gh == h && gv == v)) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_gen timeout: got (%0d,%0d), expected (%0d,%0d)", gh, gv, h, v);
    end
  endtask

  task automatic glitch_at(input int h, input int v);
    gl_h = h; gl_v = v; gl_arm = 1;
    wait_gen(h, v);
  endtask

  // monitor
  always @(negedge clk) begin : mon
    int   i;
    logic mm_exp;
    pr_t  pr;
    mm_exp = 1'b0;
    i = 0;
    while (i < ev_q.size()) begin
      if (ev_q[i].at == cyc) begin
        case (ev_q[i].kind)
          K_MM:   mm_exp = 1'b1;
          K_LOCK: chk("locked", int'(bus.locked), ev_q[i].val);
          K_ERR:  chk("err_cnt", int'(bus.err_cnt), ev_q[i].val);
          K_HC:   chk("hcount", int'(bus.hcount), ev_q[i].val);
          K_VC:   chk("vcount", int'(bus.vcount), ev_q[i].val);
          default: begin
            chk("zero_counts", int'({bus.hcount, bus.vcount}), 0);
            chk("zero_flags", int'({bus.hsync, bus.vsync, bus.hblnk, bus.vblnk,
                                    bus.locked, bus.mismatch, bus.err_cnt}), 0);
          end
        endcase
        ev_q.delete(i);
      end else if (ev_q[i].at < cyc) begin
        chk("event_cycle", ev_q[i].at, cyc);
        ev_q.delete(i);
      end else begin
        i++;
      end
    end
    while (pipe_q.size() > 0 && pipe_q[0].at < cyc) void'(pipe_q.pop_front());
    if (pipe_q.size() > 0 && pipe_q[0].at == cyc) begin
      pr = pipe_q.pop_front();
      chk("sync_out", int'({bus.hsync, bus.vsync, bus.hblnk, bus.vblnk}), int'(pr.sync));
      if (bus.locked) begin
        chk("hcount_track", int'(bus.hcount), pr.h);
        chk("vcount_track", int'(bus.vcount), pr.v);
      end
    end
    chk("mismatch", int'(bus.mismatch), int'(mm_exp));
  end

  initial begin : drv
    int e, g, t;
    bus.hsync_in = 0; bus.vsync_in = 0; bus.hblnk_in = 0; bus.vblnk_in = 0;
    bus.err_clr = 0;
    #1 rst_n = 0;

    // reset state
    step(); step();
    ev(cyc, K_ZERO, 0);
    step(); step();
    #1 rst_n = 1;

    // clean source: FS at e, tracking visible in VERIFY, lock one frame later
    wait_gen(0, 0);
    e = cyc;
    ev(e + 50, K_VC, 4);
    ev(e + 51, K_HC, 1);
    ev(e + F + 1, K_LOCK, 0);
    ev(e + F + 2, K_LOCK, 1);
    ev(e + F + 7, K_HC, 5);
    ev(e + F + 7, K_VC, 0);
    repeat (3 * F) step();
    ev(cyc + 1, K_ERR, 0);
    ev(cyc + 1, K_LOCK, 1);

    // single hsync glitch while locked
    glitch_at(HSS, 2);
    g = cyc;
    ev(g + 1, K_LOCK, 1);
    ev(g + 1, K_ERR, 0);
    ev(g + 2, K_MM, 1);
    ev(g + 2, K_LOCK, 0);
    ev(g + 2, K_ERR, 1);
    ev(g + 2, K_HC, 0);
    ev(g + 2, K_VC, 0);
    wait_gen(0, 0);
    e = cyc;
    ev(e + F + 1, K_LOCK, 0);
    ev(e + F + 2, K_LOCK, 1);
    wait_gen(0, 0);

    // truncated frame (7 lines) while locked
    wait_gen(0, 1);
    trunc = 1;
    wait_gen(0, 0);
    t = cyc;
    ev(t + 1, K_LOCK, 1);
    ev(t + 2, K_MM, 1);
    ev(t + 2, K_LOCK, 0);
    ev(t + 2, K_ERR, 2);
    ev(t + 2 * F + 1, K_LOCK, 0);
    ev(t + 2 * F + 2, K_LOCK, 1);
    wait_gen(0, 0);
    wait_gen(0, 0);
    repeat (3) step();

    // 300 glitches, one per frame: count saturates
    exp_err = 2;
    for (int k = 0; k < 300; k++) begin
      glitch_at(HSS, 2);
      g = cyc;
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      ev(g + 2, K_MM, 1);
      ev(g + 2, K_ERR, exp_err);
    end

    // clear coincident with a mismatch: clear wins, pulse still fires
    glitch_at(HSS, 2);
    g = cyc;
    ev(g + 1, K_ERR, 255);
    ev(g + 2, K_MM, 1);
    ev(g + 2, K_ERR, 0);
    ev(g + 3, K_ERR, 0);
    step();
    bus.err_clr = 1;
    step();
    bus.err_clr = 0;

    // mid-frame asynchronous reset while locked
    wait_gen(0, 0);
    e = cyc;
    ev(e + F + 2, K_LOCK, 1);
    wait_gen(0, 0);
    repeat (3) step();
    wait_gen(0, 4);
    #1 rst_n = 0;
    pipe_q.delete();
    ev(cyc, K_ZERO, 0);
    step();
    ev(cyc + 1, K_ZERO, 0);
    step(); step();
    #1 rst_n = 1;
    ev(cyc + 2, K_LOCK, 0);
    wait_gen(0, 0);
    e = cyc;
    ev(e + F + 1, K_LOCK, 0);
    ev(e + F + 2, K_LOCK, 1);
    wait_gen(0, 0);
    repeat (3) step();

    // idle inputs from reset for two frames
    #1 rst_n = 0;
    pipe_q.delete();
    idle = 1;
    repeat (3) step();
    #1 rst_n = 1;
    repeat (2 * F) step();
    ev(cyc + 1, K_ZERO, 0);
    repeat (3) step();

    chk("events_pending", ev_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_timing_rx.md
# vga_timing_rx

- Receive-side counterpart of `vga_timing`.
- Takes the bare sync/blank bundle (`hsync`, `vsync`, `hblnk`, `vblnk`, no counts) from an upstream source and reconstructs `hcount`/`vcount` for 800x600@60, 40 MHz.
- Checks every cycle against the expected timing and reports lock and mismatches.
- Sits at the input of any stage that gets sync without counts, e.g. an external or re-timed video stream, so downstream drawing logic gets a full, consistent timing bundle.

## Interface
Parameters (defaults come from `vga_pkg`):
- H_TOTAL, 1056, horizontal period in clocks
- H_ACTIVE, 800, first hblnk count
- H_SYNC_START, 840, first hsync count
- H_SYNC_END, 968, first count after hsync
- V_TOTAL, 628, lines per frame
- V_ACTIVE, 600, first vblnk line
- V_SYNC_START, 601, first vsync line
- V_SYNC_END, 605, first line after vsync

Ports:
- clk40MHz  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  incoming timing, active-high
- err_clr  in  1  synchronous clear of err_cnt
- hcount, vcount  out  11 each  reconstructed counters
- hsync, vsync, hblnk, vblnk  out  1 each  inputs delayed to align with counts
- locked  out  1  one full error-free frame tracked
- mismatch  out  1  one-cycle pulse on timing error
- err_cnt  out  8  saturating mismatch count

## Operation
- Input pipeline:
  - s1 registers the four inputs.
  - s2 registers s1.
  - Output sync/blank signals are registered copies of s1.
- Frame start (FS), combinational:
  - s1.hblnk=0, s1.vblnk=0, s2.vblnk=1.
  - s2.hblnk is deliberately not required: hblnk also falls at count (0,0).
- Expected signals from counter value c=(h,v):
  - hblnk: h≥800
  - hsync: 840≤h<968
  - vblnk: v≥600
  - vsync: 601≤v≤604 for the whole line, h 0..1055, i.e. vsync changes at h=0
- States:
  - SEARCH:
    - hcount/vcount are driven to 0 and locked=0.
    - On FS: counters←(0,0), go to VERIFY.
  - VERIFY / LOCKED:
    - Next count: h+1, with h wrap 1055→0; on h wrap, v+1 with v wrap 627→0.
    - Each cycle, compare expected signals for the next count against s1.
    - Any bit differs: mismatch=1, err_cnt+1 (saturates at 255), locked←0, go to SEARCH. The counters are not updated in that cycle.
  - VERIFY→LOCKED: FS coincides with the counter wrap from (1055,627) to (0,0).
  - FS seen in VERIFY/LOCKED at any other count is a mismatch.
- err_clr:
  - Zeroes err_cnt.
  - If err_clr and a mismatch occur in the same cycle, the clear wins (err_cnt=0). The mismatch pulse still fires.
- Widths: counters are 11-bit unsigned and never exceed 1055/627.

## Timing
- Latency: generator state at edge e appears on the outputs after edge e+2. This holds for counts and sync/blank alike.
- locked rises 1 cycle after the first FS following a full tracked frame, i.e. one frame plus 2 cycles after the first FS.
- mismatch asserts 2 cycles after the offending input and lasts exactly 1 cycle.
- Reset (asynchronous, any time, including mid-frame):
  - All outputs 0, s1/s2 0, err_cnt 0, state SEARCH.
  - After release, relock needs a new FS.
- Inputs that are constant (e.g. all 0): the block stays in SEARCH with no mismatch pulses.

## Structure
- Timing constants and the state enum (`SEARCH`, `VERIFY`, `LOCKED`) live in `vga_pkg`. The constants are shared with `vga_timing`.
- One sub-module: `vga_timing_expect`, combinational, maps (h,v) to the expected hsync/vsync/hblnk/vblnk.
- `vga_timing` instantiates the same module so that generator and receiver can never disagree.

## Test plan
- **Clean source:** drive from `vga_timing` (its active-high rst = !rst_n) -> VERIFY after the first FS; locked=1 exactly one frame (1056*628 cycles) later; output hcount/vcount equal generator counts delayed 2 cycles; mismatch never asserts over 3 frames.
- **Glitch:** force hsync_in=0 for one cycle at generator hcount=900 in frame 2 -> single mismatch pulse 2 cycles later, err_cnt=1, locked=0, relock after 1 frame.
- **Early frame:** truncate one frame to 627 lines -> mismatch at the early FS, state SEARCH, locked reacquired one frame later.
- **Counter saturation and clear:** inject 300 glitches -> err_cnt=255; err_clr pulsed together with a glitch -> err_cnt=0, mismatch still pulses.
- **Mid-frame reset:** rst_n low for 3 cycles at vcount=300 -> all outputs 0 immediately (asynchronous); after release no lock until the next FS, then locked one frame later.
- **Idle inputs:** all inputs tied 0 for 2 frames -> locked=0, mismatch=0, hcount=vcount=0.
